// File: rtl/adc_acq_pkg.sv
// Shared types and constants for the ADC acquisition sequencer.
package adc_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } acq_state_t;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/adc_trigger_detect.sv
// Edge trigger detector: compares each accepted sample against the previous one,
// plus a one-shot pending force that fires on the next accepted sample.
module adc_trigger_detect
    import adc_acq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  accept,
    input  logic [DATA_WIDTH-1:0] level,
    input  logic                  trig_edge,
    input  logic                  force_req,
    input  logic                  clear,
    output logic                  hit
);

    logic [DATA_WIDTH-1:0] prev_q;
    logic                  prev_vld_q;
    logic                  force_pend_q;
    logic                  cond;

    always_comb begin
        cond = 1'b0;
        if (prev_vld_q) begin
            if (trig_edge == EDGE_RISING) begin
                cond = (prev_q < level) && (sample >= level);
            end else begin
                cond = (prev_q > level) && (sample <= level);
            end
        end
        hit = accept & (cond | force_pend_q | force_req);
    end

    always_ff @(posedge clk_i) begin
        if (rst || clear) begin
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            force_pend_q <= 1'b0;
        end else begin
            if (accept) begin
                prev_q     <= sample;
                prev_vld_q <= 1'b1;
            end
            // An accepted sample consumes any pending force.
            force_pend_q <= accept ? 1'b0 : (force_pend_q | force_req);
        end
    end

endmodule

// File: rtl/adc_acq_ctrl.sv
// Acquisition sequencer: pre-trigger / armed / post-trigger capture of SI samples
// into a circular buffer, reporting trigger address and completion.
module adc_acq_ctrl
    import adc_acq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] SI_data,
    input  logic                  SI_rdy,
    output logic                  SI_ack,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [ADDR_WIDTH-1:0] pretrig_i,
    input  logic [ADDR_WIDTH-1:0] posttrig_i,
    input  logic [DATA_WIDTH-1:0] trig_level_i,
    input  logic                  trig_edge_i,
    input  logic                  trig_force_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [ADDR_WIDTH-1:0] trig_addr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2:0]            dbg_state
);

    acq_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_nxt;
    logic [ADDR_WIDTH-1:0] cfg_pre_q, cfg_post_q;
    logic [DATA_WIDTH-1:0] cfg_level_q;
    logic                  cfg_edge_q;
    logic                  active, take, hit;
    logic                  start_go, cnt_clr, cnt_inc, trig_take;

    assign SI_ack    = SI_rdy & ~rst;
    assign active    = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign take      = SI_rdy & SI_ack & active & ~stop_i;
    assign cnt_nxt   = cnt_q + ADDR_WIDTH'(1);
    assign busy_o    = active;
    assign done_o    = (state_q == ST_DONE);
    assign dbg_state = state_q;

    adc_trigger_detect #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
        .clk_i     (clk_i),
        .rst       (rst),
        .sample    (SI_data),
        .accept    (take),
        .level     (cfg_level_q),
        .trig_edge (cfg_edge_q),
        .force_req (trig_force_i & (state_q == ST_ARMED) & ~stop_i),
        .clear     (start_go),
        .hit       (hit)
    );

    always_comb begin
        state_d   = state_q;
        start_go  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        trig_take = 1'b0;
        if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        start_go = 1'b1;
                        cnt_clr  = 1'b1;
                        state_d  = (pretrig_i == '0) ? ST_ARMED : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (take) begin
                        if (cnt_nxt == cfg_pre_q) begin
                            state_d = ST_ARMED;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (take && hit) begin
                        trig_take = 1'b1;
                        cnt_clr   = 1'b1;
                        state_d   = (cfg_post_q == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (take) begin
                        if (cnt_nxt == cfg_post_q) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cfg_pre_q   <= '0;
            cfg_post_q  <= '0;
            cfg_level_q <= '0;
            cfg_edge_q  <= EDGE_RISING;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            trig_addr_o <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_nxt;
            end
            // wr_addr_o shows the address of the write in flight and steps past it afterwards.
            if (start_go) begin
                cfg_pre_q   <= pretrig_i;
                cfg_post_q  <= posttrig_i;
                cfg_level_q <= trig_level_i;
                cfg_edge_q  <= trig_edge_i;
                wr_addr_o   <= '0;
            end else if (wr_en_o) begin
                wr_addr_o <= wr_addr_o + ADDR_WIDTH'(1);
            end
            wr_en_o <= take;
            if (take) begin
                wr_data_o <= SI_data;
            end
            if (trig_take) begin
                trig_addr_o <= wr_addr_o + ADDR_WIDTH'(wr_en_o);
            end
        end
    end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Self-checking bench for adc_acq_ctrl: scoreboarded buffer writes plus status checks.
module tb_adc_acq_ctrl;
    import adc_acq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  si_data = '0;
    logic        si_rdy = 1'b0;
    logic        start = 1'b0, start3 = 1'b0, stop = 1'b0;
    logic [11:0] pretrig = '0, posttrig = '0;
    logic [2:0]  pretrig3 = '0, posttrig3 = '0;
    logic [7:0]  trig_level = '0;
    logic        trig_edge = 1'b0, trig_force = 1'b0;

    logic        si_ack, wr_en, busy, done;
    logic [11:0] wr_addr, trig_addr;
    logic [7:0]  wr_data;
    logic [2:0]  dbg_state;
    logic        si_ack3, wr_en3, busy3, done3;
    logic [2:0]  wr_addr3, trig_addr3, dbg_state3;
    logic [7:0]  wr_data3;

    logic [19:0] exp_q[$];
    logic [19:0] exp3_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_wr  = 0;

    adc_acq_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) u_dut (
        .clk_i(clk), .rst(rst), .SI_data(si_data), .SI_rdy(si_rdy), .SI_ack(si_ack),
        .start_i(start), .stop_i(stop), .pretrig_i(pretrig), .posttrig_i(posttrig),
        .trig_level_i(trig_level), .trig_edge_i(trig_edge), .trig_force_i(trig_force),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .trig_addr_o(trig_addr),
        .busy_o(busy), .done_o(done), .dbg_state(dbg_state)
    );

    adc_acq_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) u_dut3 (
        .clk_i(clk), .rst(rst), .SI_data(si_data), .SI_rdy(si_rdy), .SI_ack(si_ack3),
        .start_i(start3), .stop_i(1'b0), .pretrig_i(pretrig3), .posttrig_i(posttrig3),
        .trig_level_i(trig_level), .trig_edge_i(trig_edge), .trig_force_i(trig_force),
        .wr_en_o(wr_en3), .wr_addr_o(wr_addr3), .wr_data_o(wr_data3), .trig_addr_o(trig_addr3),
        .busy_o(busy3), .done_o(done3), .dbg_state(dbg_state3)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every observed write pops the oldest expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && wr_en === 1'b1) begin
            n_wr++;
            e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
            check("wr", {12'h0, wr_addr, wr_data}, e);
        end
        if (!rst && wr_en3 === 1'b1) begin
            e = (exp3_q.size() != 0) ? 32'(exp3_q.pop_front()) : 32'hDEAD_BEEF;
            check("wr3", {21'h0, wr_addr3, wr_data3}, e);
        end
    end

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        si_data = d;
        si_rdy  = 1'b1;
        tick();
        si_rdy  = 1'b0;
        tick();
    endtask

    task automatic pulse_start(input logic [11:0] pre, input logic [11:0] post,
                               input logic [7:0] lvl, input logic e);
        pretrig = pre; posttrig = post; trig_level = lvl; trig_edge = e;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble config to confirm it was latched.
        pretrig = 12'h001; posttrig = 12'h001; trig_level = 8'h00; trig_edge = ~e;
    endtask

    task automatic pulse_force();
        trig_force = 1'b1;
        tick();
        trig_force = 1'b0;
    endtask

    initial begin
        int wr_base;
        logic [7:0] seq3[7];
        seq3 = '{8'h50, 8'h40, 8'h30, 8'h41, 8'h40, 8'h20, 8'h10};

        // Reset values, and SI_ack held low while in reset
        si_rdy = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("ack_in_rst", si_ack, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        si_rdy = 1'b0;

        // Ramp without start: ack follows rdy, nothing written
        for (int i = 0; i < 16; i++) begin
            si_data = 8'(i);
            si_rdy  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_ack", si_ack, si_rdy);
            check("idle_busy", busy, 0);
            @(posedge clk); #1;
        end
        si_rdy = 1'b0;
        tick();

        // Rising trigger at 0x80, pretrig=4 posttrig=3
        wr_base = n_wr;
        pulse_start(12'd4, 12'd3, 8'h80, EDGE_RISING);
        for (int i = 0; i < 8; i++) exp_q.push_back({12'(i), 8'(8'h7C + i)});
        for (int d = 8'h7C; d <= 8'h90; d++) begin
            send(8'(d));
            if (d == 8'h7F) check("armed_after_pre", dbg_state, ST_ARMED);
            if (d == 8'h80) check("post_after_trig", dbg_state, ST_POST);
        end
        check("t2_trig_addr", trig_addr, 12'd4);
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        check("t2_nwrites", n_wr - wr_base, 8);
        check("t2_wr_addr_after", wr_addr, 12'd8);

        // Falling trigger at 0x40, restarted from DONE
        wr_base = n_wr;
        pulse_start(12'd3, 12'd2, 8'h40, EDGE_FALLING);
        @(negedge clk);
        check("t3_done_drop", done, 0);
        check("t3_busy", busy, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) exp_q.push_back({12'(i), seq3[i]});
        for (int i = 0; i < 7; i++) send(seq3[i]);
        check("t3_trig_addr", trig_addr, 12'd4);
        check("t3_done", done, 1);
        check("t3_nwrites", n_wr - wr_base, 7);

        // Narrow buffer: address wrap and forced trigger
        trig_level = 8'h80; trig_edge = EDGE_RISING;
        pretrig3 = 3'd2; posttrig3 = 3'd1;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 14; k++) exp3_q.push_back({9'h0, 3'(k), 8'h10});
        for (int k = 0; k < 12; k++) send(8'h10);
        check("t4_still_armed", dbg_state3, ST_ARMED);
        pulse_force();
        send(8'h10);
        check("t4_trig_addr", trig_addr3, 3'd4);
        send(8'h10);
        check("t4_done", done3, 1);
        send(8'h10);
        check("t4_q_empty", exp3_q.size(), 0);

        // Stop mid-POST drops the in-flight sample
        pulse_start(12'd1, 12'd5, 8'h80, EDGE_RISING);
        exp_q.push_back({12'd0, 8'h10});
        exp_q.push_back({12'd1, 8'h90});
        exp_q.push_back({12'd2, 8'h91});
        exp_q.push_back({12'd3, 8'h92});
        send(8'h10); send(8'h90); send(8'h91); send(8'h92);
        check("t5_in_post", dbg_state, ST_POST);
        si_data = 8'h93; si_rdy = 1'b1; stop = 1'b1;
        tick();
        si_rdy = 1'b0; stop = 1'b0;
        @(negedge clk);
        check("t5_stop_state", dbg_state, ST_IDLE);
        check("t5_stop_busy", busy, 0);
        check("t5_stop_wr_en", wr_en, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)));
        pretrig = 12'd0; stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        @(negedge clk);
        check("t5_stop_start_state", dbg_state, ST_IDLE);
        check("t5_stop_start_busy", busy, 0);
        @(posedge clk); #1;
        send(8'h99);

        // pretrig=0, posttrig=0: straight to ARMED, one forced write at 0
        wr_base = n_wr;
        pulse_start(12'd0, 12'd0, 8'h80, EDGE_RISING);
        @(negedge clk);
        check("t6_direct_armed", dbg_state, ST_ARMED);
        @(posedge clk); #1;
        pulse_force();
        exp_q.push_back({12'd0, 8'h90});
        send(8'h90);
        check("t6_done", done, 1);
        check("t6_trig_addr", trig_addr, 12'd0);
        send(8'h91);
        check("t6_nwrites", n_wr - wr_base, 1);

        tick(); tick();
        check("final_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
